pick_best_mode_rd: RTL and testbench

- Parametrised rate-distortion mode picker; successor to the fixed 4-mode chroma picker.
- Sequences up to NUM_MODES candidate predictions through an external reconstruct engine, one at a time, using a start/done handshake.
- Combines the returned SSE and coefficient-rate sum with a per-mode fixed cost and lambda into a score, then latches the best candidate's reconstruction, levels and nz.
- Serves luma-16, luma-4 and chroma pickers by parameter choice; also pulses the diffusion-error store trigger at completion.

---
 rtl/pick_best_mode_rd_if.sv | 30 +++
 rtl/pick_best_mode_rd.sv | 194 +++++++++++++++++++
 tb/tb_pick_best_mode_rd.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pick_best_mode_rd_if.sv
// Reconstruct-engine handshake between the RD mode picker and its engine.
// The picker drives eval_start/eval_mode; the engine returns sse, rate and payloads.
interface pick_best_mode_rd_if #(
    parameter int MODE_W = 4,
    parameter int PIX_W  = 1024,
    parameter int LVL_W  = 2048,
    parameter int NZ_W   = 32
);
    logic              eval_start;
    logic [MODE_W-1:0] eval_mode;
    logic              sse_done;
    logic [31:0]       sse;
    logic              rate_done;
    logic [31:0]       rate_sum;
    logic [PIX_W-1:0]  eval_out;
    logic [LVL_W-1:0]  eval_levels;
    logic [NZ_W-1:0]   eval_nz;

    modport master (
        output eval_start, eval_mode,
        input  sse_done, sse, rate_done, rate_sum,
        input  eval_out, eval_levels, eval_nz
    );

    modport slave (
        input  eval_start, eval_mode,
        output sse_done, sse, rate_done, rate_sum,
        output eval_out, eval_levels, eval_nz
    );
endinterface

// File: rtl/pick_best_mode_rd.sv
// Rate-distortion mode picker: evaluates enabled modes high to low, keeps the best.
// Optional macro PICK_BEST_EARLY_EXIT_EN adds early_thresh for an early exit.
module pick_best_mode_rd #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 4,
    parameter int PIX_W     = 1024,
    parameter int LVL_W     = 2048,
    parameter int NZ_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [31:0]            lambda,
    input  logic [NUM_MODES-1:0]   mode_mask,
    input  logic [16*NUM_MODES-1:0] fixed_cost,
`ifdef PICK_BEST_EARLY_EXIT_EN
    input  logic [63:0]            early_thresh,
`endif
    pick_best_mode_rd_if.master    eng,
    output logic [MODE_W-1:0]      best_mode,
    output logic [63:0]            best_score,
    output logic [PIX_W-1:0]       out,
    output logic [LVL_W-1:0]       levels,
    output logic [NZ_W-1:0]        nz,
    output logic                   valid,
    output logic                   sde_start,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_ISSUE, S_WAIT,
        S_SCORE, S_COMP, S_STORE, S_DONE
    } state_t;

    state_t                state;
    logic [31:0]           lam_q;
    logic [NUM_MODES-1:0]  mask_q;
    logic [MODE_W-1:0]     cursor;
    logic                  first;
    logic [31:0]           sse_q;
    logic [31:0]           rate_q;
    logic                  sse_seen;
    logic                  rate_seen;
    logic [63:0]           score_q;
`ifdef PICK_BEST_EARLY_EXIT_EN
    logic [63:0]           thresh_q;
`endif

    logic [15:0] cost;
    logic        sel_en;
    logic        last;
    logic [47:0] rate_term;
    logic [79:0] prod;
    logic [80:0] sum;
    logic [63:0] score_sat;
    logic        better;

    // Per-cursor mode enable and fixed cost.
    always_comb begin
        cost   = '0;
        sel_en = 1'b0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (cursor == MODE_W'(i)) begin
                cost   = fixed_cost[16*i +: 16];
                sel_en = mask_q[i];
            end
        end
    end

    assign last      = (cursor == '0);
    assign rate_term = {6'b0, rate_q, 10'b0} + {32'b0, cost};
    assign prod      = {32'b0, rate_term} * {48'b0, lam_q};
    assign sum       = {1'b0, prod} + {41'b0, sse_q, 8'b0};
    assign score_sat = (|sum[80:64]) ? '1 : sum[63:0];
    assign better    = first || (score_q <= best_score);

    // Pick sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lam_q          <= '0;
            mask_q         <= '0;
            cursor         <= '0;
            first          <= 1'b0;
            sse_q          <= '0;
            rate_q         <= '0;
            sse_seen       <= 1'b0;
            rate_seen      <= 1'b0;
            score_q        <= '0;
`ifdef PICK_BEST_EARLY_EXIT_EN
            thresh_q       <= '0;
`endif
            eng.eval_start <= 1'b0;
            eng.eval_mode  <= '0;
            best_mode      <= '0;
            best_score     <= '0;
            out            <= '0;
            levels         <= '0;
            nz             <= '0;
            valid          <= 1'b0;
            sde_start      <= 1'b0;
            done           <= 1'b0;
        end else begin
            eng.eval_start <= 1'b0;
            sde_start      <= 1'b0;
            done           <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        lam_q  <= lambda;
                        mask_q <= mode_mask;
                        cursor <= MODE_W'(NUM_MODES - 1);
                        first  <= 1'b1;
                        valid  <= 1'b0;
`ifdef PICK_BEST_EARLY_EXIT_EN
                        thresh_q <= early_thresh;
`endif
                        state  <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (sel_en) begin
                        state <= S_ISSUE;
                    end else if (last) begin
                        state <= S_DONE;
                    end else begin
                        cursor <= cursor - 1'b1;
                    end
                end
                S_ISSUE: begin
                    eng.eval_start <= 1'b1;
                    eng.eval_mode  <= cursor;
                    sse_seen       <= 1'b0;
                    rate_seen      <= 1'b0;
                    state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng.sse_done) begin
                        sse_q    <= eng.sse;
                        sse_seen <= 1'b1;
                    end
                    if (eng.rate_done) begin
                        rate_q    <= eng.rate_sum;
                        rate_seen <= 1'b1;
                    end
                    if (sse_seen && rate_seen) begin
                        state <= S_SCORE;
                    end
                end
                S_SCORE: begin
                    score_q <= score_sat;
                    state   <= S_COMP;
                end
                S_COMP: begin
                    if (better) begin
                        state <= S_STORE;
                    end else if (last) begin
                        state <= S_DONE;
                    end else begin
                        cursor <= cursor - 1'b1;
                        state  <= S_SEL;
                    end
                end
                S_STORE: begin
                    best_mode  <= cursor;
                    best_score <= score_q;
                    out        <= eng.eval_out;
                    levels     <= eng.eval_levels;
                    nz         <= eng.eval_nz;
                    first      <= 1'b0;
                    valid      <= 1'b1;
`ifdef PICK_BEST_EARLY_EXIT_EN
                    if (thresh_q != '0 && score_q <= thresh_q) begin
                        state <= S_DONE;
                    end else
`endif
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        cursor <= cursor - 1'b1;
                        state  <= S_SEL;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    sde_start <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pick_best_mode_rd.sv
// Directed bench for pick_best_mode_rd with a behavioural reconstruct engine.
// Table vectors plus hand sequences for busy-start, reset and early exit.
module tb_pick_best_mode_rd;
    localparam int NM = 4;
    localparam int MW = 4;
    localparam int PW = 1024;
    localparam int LW = 2048;
    localparam int ZW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [31:0]     lambda;
    logic [NM-1:0]   mode_mask;
    logic [16*NM-1:0] fixed_cost;
`ifdef PICK_BEST_EARLY_EXIT_EN
    logic [63:0]     early_thresh;
`endif
    logic [MW-1:0]   best_mode;
    logic [63:0]     best_score;
    logic [PW-1:0]   out;
    logic [LW-1:0]   levels;
    logic [ZW-1:0]   nz;
    logic            valid;
    logic            sde_start;
    logic            done;

    pick_best_mode_rd_if #(.MODE_W(MW), .PIX_W(PW), .LVL_W(LW), .NZ_W(ZW)) eng ();

    pick_best_mode_rd #(
        .NUM_MODES(NM), .MODE_W(MW), .PIX_W(PW), .LVL_W(LW), .NZ_W(ZW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lambda(lambda),
        .mode_mask(mode_mask), .fixed_cost(fixed_cost),
`ifdef PICK_BEST_EARLY_EXIT_EN
        .early_thresh(early_thresh),
`endif
        .eng(eng), .best_mode(best_mode), .best_score(best_score),
        .out(out), .levels(levels), .nz(nz), .valid(valid),
        .sde_start(sde_start), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   mask;
        logic [31:0]  lam;
        logic [63:0]  costs;
        logic [127:0] sse_v;
        logic [127:0] rate_v;
        logic [7:0]   order;
        logic [3:0]   exp_mode;
        logic [63:0]  exp_score;
        logic         exp_valid;
        int           exp_evals;
        logic [15:0]  exp_seq;
        int           pay;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int n_evals = 0;
    int done_cnt = 0;
    int sde_cnt = 0;
    logic [3:0]   log_m [0:255];
    logic [127:0] cur_sse;
    logic [127:0] cur_rate;
    logic [7:0]   cur_order;
    int           cur_pay;

    function automatic logic [PW-1:0] mk_pix(input int v, input int m);
        return PW'({v[7:0], m[3:0], 20'hC0FFE});
    endfunction
    function automatic logic [LW-1:0] mk_lvl(input int v, input int m);
        return LW'({v[7:0], m[3:0], 20'hBEEF5});
    endfunction
    function automatic logic [ZW-1:0] mk_nz(input int v, input int m);
        return {v[7:0], m[3:0], 20'h0A5A5};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ..%h, want ..%h", name, act[63:0], exp[63:0]);
    endtask

    // Behavioural engine: answers each eval_start after a fixed latency.
    initial begin : engine
        int m;
        logic [1:0] o;
        logic [31:0] s;
        logic [31:0] r;
        eng.sse_done    = 1'b0;
        eng.rate_done   = 1'b0;
        eng.sse         = '0;
        eng.rate_sum    = '0;
        eng.eval_out    = '0;
        eng.eval_levels = '0;
        eng.eval_nz     = '0;
        forever begin
            @(negedge clk);
            if (eng.eval_start === 1'b1) begin
                m = int'(eng.eval_mode);
                log_m[n_evals % 256] = eng.eval_mode;
                n_evals++;
                eng.eval_out    = mk_pix(cur_pay, m);
                eng.eval_levels = mk_lvl(cur_pay, m);
                eng.eval_nz     = mk_nz(cur_pay, m);
                s = cur_sse[32*m +: 32];
                r = cur_rate[32*m +: 32];
                o = cur_order[2*m +: 2];
                repeat (4) @(negedge clk);
                if (o == 2'd1) begin
                    eng.sse = s; eng.sse_done = 1'b1;
                    @(negedge clk);
                    eng.sse_done = 1'b0;
                    eng.rate_sum = r; eng.rate_done = 1'b1;
                    @(negedge clk);
                    eng.rate_done = 1'b0;
                end else if (o == 2'd2) begin
                    eng.rate_sum = r; eng.rate_done = 1'b1;
                    @(negedge clk);
                    eng.rate_done = 1'b0;
                    eng.sse = s; eng.sse_done = 1'b1;
                    @(negedge clk);
                    eng.sse_done = 1'b0;
                end else begin
                    eng.sse = s; eng.sse_done = 1'b1;
                    eng.rate_sum = r; eng.rate_done = 1'b1;
                    @(negedge clk);
                    eng.sse_done = 1'b0;
                    eng.rate_done = 1'b0;
                end
            end
        end
    end

    // Pulse counters for done and sde_start.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (sde_start === 1'b1) sde_cnt++;
        end
    end

    task automatic run_pick(input string tag, input vec_t v, input logic busy_start,
                            output int lat);
        int ev0, d0, s0, k;
        logic [15:0] seq;
        ev0 = n_evals;
        cur_sse = v.sse_v;
        cur_rate = v.rate_v;
        cur_order = v.order;
        cur_pay = v.pay;
        @(negedge clk);
        d0 = done_cnt;
        s0 = sde_cnt;
        lambda = v.lam;
        mode_mask = v.mask;
        fixed_cost = v.costs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 3000) begin
            if (busy_start && k == 8) begin
                start = 1'b1;
                lambda = 32'd100;
                mode_mask = 4'b0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        lat = k;
        if (k >= 3000) begin
            n_tot++;
            $display("FAIL %s_timeout: got no done, want done", tag);
        end
        chk({tag, "_sde"}, 64'(sde_start), 64'd1);
        chk({tag, "_mode"}, 64'(best_mode), 64'(v.exp_mode));
        chk({tag, "_score"}, best_score, v.exp_score);
        chk({tag, "_valid"}, 64'(valid), 64'(v.exp_valid));
        chkw({tag, "_out"}, {1024'b0, out}, {1024'b0, mk_pix(v.pay, int'(v.exp_mode))});
        chkw({tag, "_levels"}, levels, mk_lvl(v.pay, int'(v.exp_mode)));
        chk({tag, "_nz"}, 64'(nz), 64'(mk_nz(v.pay, int'(v.exp_mode))));
        chk({tag, "_evals"}, 64'(n_evals - ev0), 64'(v.exp_evals));
        seq = '0;
        for (int j = ev0; j < n_evals; j++) seq = {seq[11:0], log_m[j % 256]};
        chk({tag, "_seq"}, 64'(seq), 64'(v.exp_seq));
        repeat (3) @(negedge clk);
        chk({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_nsde"}, 64'(sde_cnt - s0), 64'd1);
    endtask

    localparam logic [63:0] C0 = {16'd642, 16'd439, 16'd984, 16'd302};

    initial begin : main
        vec_t vt [7];
        vec_t v0;
        vec_t ve;
        int lat, d0, k;

        vt[0] = '{4'hF, 32'd2, C0, {32'd1, 32'd1, 32'd1, 32'd1}, 128'd0, 8'd0,
                  4'd0, 64'd860, 1'b1, 4, 16'h3210, 0};
        vt[1] = '{4'hF, 32'd2, {4{16'd500}}, {32'd1, 32'd1, 32'd1, 32'd1}, 128'd0, 8'd0,
                  4'd0, 64'd1256, 1'b1, 4, 16'h3210, 1};
        vt[2] = '{4'h4, 32'd1, C0, {32'd0, 32'd10, 32'd0, 32'd0}, {32'd0, 32'd3, 32'd0, 32'd0},
                  8'd0, 4'd2, 64'd6071, 1'b1, 1, 16'h0002, 2};
        vt[3] = '{4'h3, 32'd3, C0, {32'd0, 32'd0, 32'd100, 32'd50}, {32'd0, 32'd0, 32'd2, 32'd5},
                  8'b0000_0010, 4'd0, 64'd29066, 1'b1, 2, 16'h0010, 3};
        vt[4] = '{4'h8, 32'hFFFF_FFFF, C0, {32'hFFFF_FFFF, 96'd0}, {32'hFFFF_FFFF, 96'd0},
                  8'd0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 16'h0003, 4};
        vt[5] = '{4'h0, 32'd7, C0, 128'd0, 128'd0, 8'd0,
                  4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 16'h0000, 4};
        vt[6] = '{4'hA, 32'd1, C0, 128'd0, 128'd0, 8'b0100_0000,
                  4'd3, 64'd642, 1'b1, 2, 16'h0031, 6};

        rst_n = 1'b0;
        start = 1'b0;
        lambda = '0;
        mode_mask = '0;
        fixed_cost = '0;
`ifdef PICK_BEST_EARLY_EXIT_EN
        early_thresh = '0;
`endif
        cur_sse = '0;
        cur_rate = '0;
        cur_order = '0;
        cur_pay = 0;
        repeat (3) @(negedge clk);
        chk("rst_mode", 64'(best_mode), 64'd0);
        chk("rst_score", best_score, 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_done", 64'({done, sde_start, eng.eval_start}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_pick($sformatf("v%0d", i), vt[i], 1'b0, lat);
            if (vt[i].mask == 4'h0) chk($sformatf("v%0d_lat", i), 64'(lat), 64'(NM + 2));
        end

        v0 = vt[0];
        run_pick("busy", v0, 1'b1, lat);

        cur_sse = v0.sse_v;
        cur_rate = v0.rate_v;
        cur_order = v0.order;
        cur_pay = 9;
        d0 = done_cnt;
        lambda = v0.lam;
        mode_mask = v0.mask;
        fixed_cost = v0.costs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (eng.eval_start !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rw_issue", 64'(eng.eval_start), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_mode", 64'(best_mode), 64'd0);
        chk("rw_score", best_score, 64'd0);
        chk("rw_valid", 64'(valid), 64'd0);
        chkw("rw_out", {1024'b0, out}, 2048'd0);
        chkw("rw_levels", levels, 2048'd0);
        chk("rw_nz", 64'(nz), 64'd0);
        chk("rw_ctl", 64'({done, sde_start, eng.eval_start, eng.eval_mode}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rw_nodone", 64'(done_cnt - d0), 64'd0);
        run_pick("rw_new", v0, 1'b0, lat);

`ifdef PICK_BEST_EARLY_EXIT_EN
        ve = '{4'hF, 32'd1, {16'd1000, 16'd439, 16'd984, 16'd302}, 128'd0, 128'd0, 8'd0,
               4'd3, 64'd1000, 1'b1, 1, 16'h0003, 10};
        early_thresh = 64'd1500;
        run_pick("early", ve, 1'b0, lat);
        early_thresh = '0;
`else
        ve = vt[6];
`endif
        ve.pay = 11;
        run_pick("late", ve, 1'b0, lat);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: got hang, want finish");
        $fatal(1, "bench timeout");
    end
endmodule
